// File: rtl/swc_sequencer.sv
// swc_sequencer: expands a count-to-zero request into Swc LD0/LD1/LD2 + CCU/CCD, SWCSEQ_SKIPLOAD_EN skips loads of bytes the Swc already holds
`ifndef Swc_NOP
`define Swc_NOP 4'h0
`endif
`ifndef Swc_LD0
`define Swc_LD0 4'h1
`endif
`ifndef Swc_LD1
`define Swc_LD1 4'h2
`endif
`ifndef Swc_LD2
`define Swc_LD2 4'h3
`endif
`ifndef Swc_CCU
`define Swc_CCU 4'h4
`endif
`ifndef Swc_CCD
`define Swc_CCD 4'h5
`endif

module swc_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_value,
  input  logic        req_dir,
  input  logic        abort,
  output logic [11:0] swc_inst,
  output logic        swc_inst_en,
  input  logic [23:0] swc_counter,
  input  logic        swc_ready,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic        fault
);
  typedef enum logic [2:0] {IDLE, LOAD0, LOAD1, LOAD2, START, RUN, STOP, FAULT} state_t;
  state_t state, nxt;
  logic [23:0] val, val_n;
  logic dir, dir_n, acc, en_n, done_n, abd_n;
  logic [2:0] skip_now;
  logic [2:1] skip, skip_n;
  logic [11:0] inst_n;
  assign acc = req_valid && req_ready;
`ifdef SWCSEQ_SKIPLOAD_EN
  assign skip_now = {req_value[23:16] == swc_counter[23:16], req_value[15:8] == swc_counter[15:8],
                     req_value[7:0] == swc_counter[7:0]};
`else
  assign skip_now = 3'b000;
`endif
  assign val_n = acc ? req_value : val;
  assign dir_n = acc ? req_dir : dir;
  assign skip_n = acc ? skip_now[2:1] : skip;
  always_comb begin
    nxt = state;
    if (state != FAULT && !swc_ready) nxt = FAULT;
    else
      case (state)
        IDLE:    nxt = !req_valid ? IDLE : !skip_now[0] ? LOAD0 : !skip_now[1] ? LOAD1 : !skip_now[2] ? LOAD2 : START;
        LOAD0:   nxt = abort ? STOP : !skip[1] ? LOAD1 : !skip[2] ? LOAD2 : START;
        LOAD1:   nxt = abort ? STOP : !skip[2] ? LOAD2 : START;
        LOAD2:   nxt = abort ? STOP : START;
        START:   nxt = val == 24'd0 ? IDLE : abort ? STOP : RUN;
        RUN:     nxt = swc_counter == 24'd0 ? IDLE : abort ? STOP : RUN;
        STOP:    nxt = IDLE;
        default: nxt = FAULT;
      endcase
  end
  assign done_n = nxt == IDLE && (state == START || state == RUN);
  assign abd_n = nxt == IDLE && state == STOP;
  assign en_n = nxt inside {LOAD0, LOAD1, LOAD2, STOP} || (nxt == START && val_n != 24'd0);
  assign inst_n = nxt == LOAD0 ? {`Swc_LD0, val_n[7:0]} :
                  nxt == LOAD1 ? {`Swc_LD1, val_n[15:8]} :
                  nxt == LOAD2 ? {`Swc_LD2, val_n[23:16]} :
                  (nxt == START && val_n != 24'd0) ? {dir_n ? `Swc_CCU : `Swc_CCD, 8'h00} :
                  {`Swc_NOP, 8'h00};
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      val <= '0;
      dir <= 1'b0;
      skip <= '0;
      swc_inst <= {`Swc_NOP, 8'h00};
      swc_inst_en <= 1'b0;
      req_ready <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      aborted <= 1'b0;
      fault <= 1'b0;
    end else begin
      state <= nxt;
      val <= val_n;
      dir <= dir_n;
      skip <= skip_n;
      swc_inst <= inst_n;
      swc_inst_en <= en_n;
      req_ready <= nxt == IDLE;
      busy <= nxt != IDLE && nxt != FAULT;
      done <= done_n;
      aborted <= abd_n;
      fault <= nxt == FAULT;
    end
  end
endmodule

// File: tb/tb_swc_sequencer.sv
// tb_swc_sequencer: drives swc_sequencer against a behavioural Swc and a schedule-level expectation model
module tb_swc_sequencer;
  localparam logic [3:0] OP_NOP = 4'h0, OP_LD0 = 4'h1, OP_LD1 = 4'h2, OP_LD2 = 4'h3, OP_CCU = 4'h4, OP_CCD = 4'h5;
  localparam logic [3:0] LD_OP [3] = '{OP_LD0, OP_LD1, OP_LD2};
  localparam int TL = 64;
`ifdef SWCSEQ_SKIPLOAD_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b1, req_valid = 1'b0, req_dir = 1'b0, abort = 1'b0, swc_ready = 1'b1;
  logic [23:0] req_value = '0;
  logic req_ready, swc_inst_en, busy, done, aborted, fault;
  logic [11:0] swc_inst;
  logic [23:0] swc_counter;
  logic preload = 1'b0, run, dn;
  logic [23:0] pre_val = '0, cnt_at_acc;
  logic [17:0] obs [TL];
  logic [17:0] exp_t [TL];
  int total = 0, bad = 0, end_idx, done_idx, n_loads;

  swc_sequencer dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_value(req_value), .req_dir(req_dir), .abort(abort), .swc_inst(swc_inst),
    .swc_inst_en(swc_inst_en), .swc_counter(swc_counter), .swc_ready(swc_ready),
    .busy(busy), .done(done), .aborted(aborted), .fault(fault)
  );

  always #5 clock = ~clock;

  // Swc stand-in: loads bytes, counts after CCU/CCD, halts on reaching zero or on NOP
  always @(posedge clock) begin
    if (reset) begin
      swc_counter <= '0;
      run <= 1'b0;
      dn <= 1'b0;
    end else if (preload) begin
      swc_counter <= pre_val;
      run <= 1'b0;
    end else if (swc_inst_en) begin
      case (swc_inst[11:8])
        OP_LD0: begin swc_counter[7:0] <= swc_inst[7:0]; run <= 1'b0; end
        OP_LD1: begin swc_counter[15:8] <= swc_inst[7:0]; run <= 1'b0; end
        OP_LD2: begin swc_counter[23:16] <= swc_inst[7:0]; run <= 1'b0; end
        OP_CCD: begin swc_counter <= swc_counter - 24'd1; dn <= 1'b1; run <= swc_counter != 24'd1; end
        OP_CCU: begin swc_counter <= swc_counter + 24'd1; dn <= 1'b0; run <= swc_counter != 24'hFFFFFF; end
        default: run <= 1'b0;
      endcase
    end else if (run) begin
      swc_counter <= dn ? swc_counter - 24'd1 : swc_counter + 24'd1;
      run <= dn ? swc_counter != 24'd1 : swc_counter != 24'hFFFFFF;
    end
  end

  task automatic send(input logic [23:0] v, input logic d, input bit wait_edge);
    if (wait_edge) @(negedge clock);
    req_valid = 1'b1;
    req_value = v;
    req_dir = d;
    cnt_at_acc = swc_counter;
    @(posedge clock);
    #1 req_valid = 1'b0;
  endtask

  // obs[i] is the cycle i+1 after the accept edge: {inst, en, done, aborted, ready, busy, fault}
  task automatic capture(input int n, input int a, input int f);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      obs[i] = {swc_inst, swc_inst_en, done, aborted, req_ready, busy, fault};
      abort = (i == a);
      swc_ready = (i != f);
    end
    abort = 1'b0;
    swc_ready = 1'b1;
  endtask

  task automatic build_exp(input logic [23:0] v, input logic d, input logic [23:0] c, input int a);
    bit [2:0] sk;
    int k;
    for (int b = 0; b < 3; b++) sk[b] = SKIP && (v[8*b +: 8] == c[8*b +: 8]);
    for (int i = 0; i < TL; i++) exp_t[i] = {OP_NOP, 8'h00, 6'b000000};
    n_loads = 0;
    for (int b = 0; b < 3; b++)
      if (!sk[b]) begin
        exp_t[n_loads][17:5] = {LD_OP[b], v[8*b +: 8], 1'b1};
        n_loads++;
      end
    k = v == 24'd0 ? 0 : d ? (1 << 24) - int'(v) : int'(v);
    done_idx = n_loads + 1 + k;
    if (v != 24'd0) exp_t[n_loads][17:5] = {d ? OP_CCU : OP_CCD, 8'h00, 1'b1};
    if (a >= 0 && a < done_idx - 1) begin
      for (int i = a + 1; i < TL; i++) exp_t[i][17:5] = {OP_NOP, 8'h00, 1'b0};
      exp_t[a + 1][5] = 1'b1;
      end_idx = a + 2;
      exp_t[end_idx][3] = 1'b1;
    end else begin
      end_idx = done_idx;
      if (end_idx < TL) exp_t[end_idx][4] = 1'b1;
    end
    for (int i = 0; i < TL; i++) begin
      exp_t[i][2] = i >= end_idx;
      exp_t[i][1] = i < end_idx;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    total++;
    if ({swc_inst, swc_inst_en, done, aborted, req_ready, busy, fault} !== {OP_NOP, 8'h00, 6'b000100}) begin
      bad++;
      $display("FAIL reset_state got=%h want=%h", {swc_inst, swc_inst_en, done, aborted, req_ready, busy, fault}, {OP_NOP, 8'h00, 6'b000100});
    end
    send(24'h000020, 1'b0, 1'b1);
    capture(3, -1, -1);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    total++;
    if ({swc_inst, swc_inst_en, done, aborted, req_ready, busy, fault} !== {OP_NOP, 8'h00, 6'b000100}) begin
      bad++;
      $display("FAIL reset_midop got=%h want=%h", {swc_inst, swc_inst_en, done, aborted, req_ready, busy, fault}, {OP_NOP, 8'h00, 6'b000100});
    end
  endtask

  task automatic test_down;
    send(24'h000006, 1'b0, 1'b1);
    build_exp(24'h000006, 1'b0, cnt_at_acc, -1);
    capture(end_idx + 2, -1, -1);
    for (int i = 0; i < end_idx + 2; i++) begin
      total++;
      if (obs[i] !== exp_t[i]) begin bad++; $display("FAIL down idx=%0d got=%h want=%h", i, obs[i], exp_t[i]); end
    end
  endtask

  task automatic test_up;
    send(24'hFFFFFA, 1'b1, 1'b1);
    build_exp(24'hFFFFFA, 1'b1, cnt_at_acc, -1);
    capture(end_idx + 2, -1, -1);
    for (int i = 0; i < end_idx + 2; i++) begin
      total++;
      if (obs[i] !== exp_t[i]) begin bad++; $display("FAIL up idx=%0d got=%h want=%h", i, obs[i], exp_t[i]); end
    end
  endtask

  task automatic test_abort;
    int a;
    send(24'h000100, 1'b0, 1'b1);
    build_exp(24'h000100, 1'b0, cnt_at_acc, -1);
    a = n_loads + 3;
    build_exp(24'h000100, 1'b0, cnt_at_acc, a);
    capture(end_idx + 2, a, -1);
    for (int i = 0; i < end_idx + 2; i++) begin
      total++;
      if (obs[i] !== exp_t[i]) begin bad++; $display("FAIL abort idx=%0d got=%h want=%h", i, obs[i], exp_t[i]); end
    end
  endtask

  task automatic test_simultaneous;
    int a;
    send(24'h000003, 1'b0, 1'b1);
    build_exp(24'h000003, 1'b0, cnt_at_acc, -1);
    a = done_idx - 1;
    build_exp(24'h000003, 1'b0, cnt_at_acc, a);
    capture(end_idx + 2, a, -1);
    for (int i = 0; i < end_idx + 2; i++) begin
      total++;
      if (obs[i] !== exp_t[i]) begin bad++; $display("FAIL abort_at_zero idx=%0d got=%h want=%h", i, obs[i], exp_t[i]); end
    end
    send(24'h000000, 1'b0, 1'b1);
    build_exp(24'h000000, 1'b0, cnt_at_acc, -1);
    capture(end_idx + 2, -1, -1);
    for (int i = 0; i < end_idx + 2; i++) begin
      total++;
      if (obs[i] !== exp_t[i]) begin bad++; $display("FAIL zero_value idx=%0d got=%h want=%h", i, obs[i], exp_t[i]); end
    end
  endtask

  task automatic test_back_to_back;
    send(24'h000005, 1'b0, 1'b1);
    build_exp(24'h000005, 1'b0, cnt_at_acc, -1);
    capture(end_idx + 1, -1, -1);
    for (int i = 0; i <= end_idx; i++) begin
      total++;
      if (obs[i] !== exp_t[i]) begin bad++; $display("FAIL b2b_first idx=%0d got=%h want=%h", i, obs[i], exp_t[i]); end
    end
    send(24'hFFFFFD, 1'b1, 1'b0);
    build_exp(24'hFFFFFD, 1'b1, cnt_at_acc, -1);
    capture(end_idx + 2, -1, -1);
    for (int i = 0; i < end_idx + 2; i++) begin
      total++;
      if (obs[i] !== exp_t[i]) begin bad++; $display("FAIL b2b_second idx=%0d got=%h want=%h", i, obs[i], exp_t[i]); end
    end
  endtask

  task automatic test_skipload;
    @(negedge clock);
    preload = 1'b1;
    pre_val = 24'h123400;
    @(negedge clock);
    preload = 1'b0;
    send(24'h123405, 1'b0, 1'b0);
    build_exp(24'h123405, 1'b0, cnt_at_acc, 4);
    capture(end_idx + 2, 4, -1);
    for (int i = 0; i < end_idx + 2; i++) begin
      total++;
      if (obs[i] !== exp_t[i]) begin bad++; $display("FAIL skipload idx=%0d got=%h want=%h", i, obs[i], exp_t[i]); end
    end
  endtask

  task automatic test_fault;
    send(24'h332211, 1'b0, 1'b1);
    capture(4, -1, 1);
    total++;
    if (obs[1] !== {OP_LD1, 8'h22, 6'b100010}) begin bad++; $display("FAIL fault_pre got=%h want=%h", obs[1], {OP_LD1, 8'h22, 6'b100010}); end
    for (int i = 2; i < 4; i++) begin
      total++;
      if (obs[i] !== {OP_NOP, 8'h00, 6'b000001}) begin bad++; $display("FAIL fault_entry idx=%0d got=%h want=%h", i, obs[i], {OP_NOP, 8'h00, 6'b000001}); end
    end
    req_valid = 1'b1;
    req_value = 24'h000004;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      total++;
      if ({swc_inst_en, req_ready, busy, fault} !== 4'b0001) begin bad++; $display("FAIL fault_hold cyc=%0d got=%b want=0001", i, {swc_inst_en, req_ready, busy, fault}); end
    end
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    total++;
    if ({swc_inst, swc_inst_en, done, aborted, req_ready, busy, fault} !== {OP_NOP, 8'h00, 6'b000100}) begin
      bad++;
      $display("FAIL fault_clear got=%h want=%h", {swc_inst, swc_inst_en, done, aborted, req_ready, busy, fault}, {OP_NOP, 8'h00, 6'b000100});
    end
  endtask

  task automatic test_random;
    logic [23:0] v;
    logic d;
    int a;
    repeat (14) begin
      a = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 12)) : -1;
      case ($urandom_range(0, 3))
        0: begin v = 24'($urandom_range(1, 30)); d = 1'b0; end
        1: begin v = 24'((1 << 24) - $urandom_range(1, 30)); d = 1'b1; end
        2: begin v = 24'd0; d = 1'($urandom_range(0, 1)); end
        default: begin v = 24'($urandom_range(4096, 24'hFFFFFF)); d = 1'($urandom_range(0, 1)); a = int'($urandom_range(0, 8)); end
      endcase
      send(v, d, 1'b1);
      build_exp(v, d, cnt_at_acc, a);
      capture(end_idx + 2, a, -1);
      for (int i = 0; i < end_idx + 2; i++) begin
        total++;
        if (obs[i] !== exp_t[i]) begin bad++; $display("FAIL random v=%h dir=%b abort=%0d idx=%0d got=%h want=%h", v, d, a, i, obs[i], exp_t[i]); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_down;
    test_up;
    test_abort;
    test_simultaneous;
    test_back_to_back;
    test_skipload;
    test_fault;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
